multicycle_controller: RTL and testbench

//   Moore FSM that sequences the shared instruction/data memory, PC, IR, register file and ALU
//   of the multicycle MIPS datapath. Decodes the IR opcode and steps FETCH->DECODE->exec states,

---
 rtl/multicycle_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the multicycle MIPS datapath
//
// Purpose:
//   Sequences the shared memory, PC, IR, register file and ALU of a multicycle
//   MIPS datapath. Steps FETCH -> DECODE -> per-opcode execution states and
//   drives every datapath strobe from the registered state. Counts completed
//   fetches and pulses illegal_op for one cycle after an unsupported opcode.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   opcode[5:0]    IR[31:26], valid from DECODE onward
//   zero           ALU zero flag; combined with pc_write_cond by the datapath
//   stall          memory not ready: hold state, gate write strobes
//   pc_write       unconditional PC load
//   pc_write_cond  PC load if zero
//   iord           memory address select: 0 PC, 1 ALUOut
//   mem_read       memory read strobe
//   mem_write      memory write strobe
//   ir_write       latch memory data into IR
//   mem_to_reg     writeback select: 1 MDR, 0 ALUOut
//   reg_dst        destination select: 1 rd, 0 rt
//   reg_write      register file write
//   alu_src_a      ALU A select: 0 PC, 1 reg A
//   alu_src_b[1:0] ALU B select: 00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op[1:0]    00 add, 01 sub, 10 funct
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]     current state encoding
//   illegal_op     one-cycle pulse after DECODE sees an unsupported opcode
//   instr_count    number of completed fetches (wraps)

module multicycle_controller #(
    parameter int          CNT_W   = 16,
    parameter logic [5:0]  OP_R    = 6'b000000,
    parameter logic [5:0]  OP_LW   = 6'b100011,
    parameter logic [5:0]  OP_SW   = 6'b101011,
    parameter logic [5:0]  OP_BEQ  = 6'b000100,
    parameter logic [5:0]  OP_J    = 6'b000010,
    parameter logic [5:0]  OP_ADDI = 6'b001000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             stall,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;

    logic is_r, is_lw, is_sw, is_beq, is_j, is_addi;

    // The branch decision is made in the datapath (pc_write_cond & zero);
    // the controller stays a pure Moore machine and never looks at zero.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        is_r    = (opcode == OP_R);
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);
        is_beq  = (opcode == OP_BEQ);
        is_j    = (opcode == OP_J);
        is_addi = (opcode == OP_ADDI);
    end

    // Next-state, fetch counter and illegal-opcode flag. A stall freezes all
    // three; otherwise illegal_op defaults low so it lasts exactly one cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        if (!stall) begin
            illegal_d = 1'b0;
            case (state_q)
                S_FETCH: begin
                    state_d = S_DECODE;
                    count_d = count_q + CNT_W'(1);
                end
                S_DECODE: begin
                    if (is_lw || is_sw) begin
                        state_d = S_MEM_ADDR;
                    end else if (is_r) begin
                        state_d = S_EXEC;
                    end else if (is_beq) begin
                        state_d = S_BRANCH;
                    end else if (is_j) begin
                        state_d = S_JUMP;
                    end else if (is_addi) begin
                        state_d = S_ADDI_EX;
                    end else begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                end
                S_MEM_ADDR: begin
                    if (is_lw) begin
                        state_d = S_MEM_RD;
                    end else if (is_sw) begin
                        state_d = S_MEM_WR;
                    end else begin
                        // opcode changed under us; abandon rather than guess
                        state_d = S_FETCH;
                    end
                end
                S_MEM_RD:  state_d = S_MEM_WB;
                S_EXEC:    state_d = S_R_WB;
                S_ADDI_EX: state_d = S_ADDI_WB;
                S_MEM_WB,
                S_MEM_WR,
                S_R_WB,
                S_BRANCH,
                S_JUMP,
                S_ADDI_WB: state_d = S_FETCH;
                // encodings 12-15 recover to FETCH
                default:   state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore outputs. Mux selects follow the state even while stalled or in
    // reset so the datapath keeps a stable view; only state-changing strobes
    // are gated.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut
                alu_src_b = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: begin
            end
        endcase

        if (stall || reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
        end
        if (reset) begin
            mem_read = 1'b0;
        end
    end

    assign state       = state_q;
    assign illegal_op  = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller

module tb_multicycle_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b1;
    logic             reset, zero, stall;
    logic [5:0]       opcode;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .stall(stall),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      known;
        int      st;
        bit      ill;
        int      cnt;
        bit      pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        int      asb, aop, psrc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // reference model: an instruction is a list of states taken from its opcode
    logic [5:0] prog[$];
    logic [5:0] cur_op;
    int         seq[$];
    int         idx = 0;
    bit         need_op = 1;
    int         m_cnt = 0;
    bit         m_ill = 0;
    bit         m_known = 0;

    function automatic bit supported(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    task automatic load_seq(input logic [5:0] op);
        seq.delete();
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 10, 11};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 9};
            default:   seq = '{0, 1};
        endcase
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 6))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b000010;
            5: return 6'b001000;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic int cur_state();
        return need_op ? 0 : seq[idx];
    endfunction

    task automatic step(input logic rst, input logic stl);
        exp_t e;
        int   s;
        if (need_op) begin
            cur_op  = (prog.size() > 0) ? prog.pop_front() : rand_op();
            load_seq(cur_op);
            idx     = 0;
            need_op = 0;
        end
        reset  = rst;
        stall  = stl;
        zero   = 1'($urandom);
        opcode = cur_op;

        s = seq[idx];
        e = '{default: 0};
        e.known = m_known;
        e.st    = s;
        e.ill   = m_ill;
        e.cnt   = m_cnt;
        case (s)
            0:  begin e.mr = 1; e.irw = 1; e.asb = 1; e.pcw = 1; end
            1:  e.asb = 3;
            2, 10: begin e.asa = 1; e.asb = 2; end
            3:  begin e.mr = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; end
            5:  begin e.mw = 1; e.iord = 1; end
            6:  begin e.asa = 1; e.aop = 2; end
            7:  begin e.rw = 1; e.rdst = 1; end
            11: e.rw = 1;
            8:  begin e.asa = 1; e.aop = 1; e.pcwc = 1; e.psrc = 1; end
            9:  begin e.pcw = 1; e.psrc = 2; end
            default: ;
        endcase
        if (stl || rst) begin
            e.pcw = 0; e.pcwc = 0; e.irw = 0; e.rw = 0; e.mw = 0;
        end
        if (rst) e.mr = 0;
        q.push_back(e);

        @(posedge clk);
        if (rst) begin
            m_known = 1;
            m_cnt   = 0;
            m_ill   = 0;
            need_op = 1;
        end else if (!stl) begin
            m_ill = (s == 1) && !supported(cur_op);
            if (idx == 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            idx++;
            if (idx == seq.size()) need_op = 1;
        end
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // monitor: every cycle the DUT presents a full control word
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_write", int'(pc_write), int'(e.pcw));
            chk("pc_write_cond", int'(pc_write_cond), int'(e.pcwc));
            chk("mem_read", int'(mem_read), int'(e.mr));
            chk("mem_write", int'(mem_write), int'(e.mw));
            chk("ir_write", int'(ir_write), int'(e.irw));
            chk("reg_write", int'(reg_write), int'(e.rw));
            if (e.known) begin
                chk("state", int'(state), e.st);
                chk("iord", int'(iord), int'(e.iord));
                chk("mem_to_reg", int'(mem_to_reg), int'(e.m2r));
                chk("reg_dst", int'(reg_dst), int'(e.rdst));
                chk("alu_src_a", int'(alu_src_a), int'(e.asa));
                chk("alu_src_b", int'(alu_src_b), e.asb);
                chk("alu_op", int'(alu_op), e.aop);
                chk("pc_source", int'(pc_source), e.psrc);
                chk("illegal_op", int'(illegal_op), int'(e.ill));
                chk("instr_count", int'(instr_count), e.cnt);
            end
            cyc++;
        end
    end

    task automatic run_to_state(input int target, input string nm);
        int n = 0;
        while (cur_state() != target && n < 20) begin
            step(0, 0);
            n++;
        end
        chk(nm, cur_state(), target);
    endtask

    initial begin
        reset = 1; stall = 0; zero = 0; opcode = 6'b0;

        // reset held two cycles
        step(1, 0);
        step(1, 0);

        // lw: 0,1,2,3,4
        prog.push_back(6'b100011);
        repeat (5) step(0, 0);

        // sw with three stalled cycles in MEM_WR
        prog.push_back(6'b101011);
        run_to_state(5, "reach_mem_wr");
        repeat (3) step(0, 1);
        step(0, 0);

        // beq with zero driven randomly; outputs do not depend on it
        prog.push_back(6'b000100);
        repeat (3) step(0, 0);

        // unsupported opcode
        prog.push_back(6'b111111);
        repeat (3) step(0, 0);

        // 16 jumps: counter wraps through 15 -> 0
        repeat (16) prog.push_back(6'b000010);
        repeat (48) step(0, 0);

        // reset in MEM_RD
        prog.push_back(6'b100011);
        run_to_state(3, "reach_mem_rd");
        step(1, 0);
        step(0, 0);

        // randomized traffic with stalls and occasional resets
        repeat (500) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20));
        end

        step(0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
